// File: rtl/mmss_timer_pkg.sv
// Shared constants and helpers for the MM:SS timer: seven-segment codes,
// anode patterns, field encoding and wrapping two-digit BCD step functions.
package mmss_timer_pkg;

  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  localparam logic [7:0] SEC_MAX_BCD = 8'h59;

  typedef enum logic {
    FIELD_MIN = 1'b0,
    FIELD_SEC = 1'b1
  } field_e;

  localparam logic [3:0] AN_S0 = 4'b1110;
  localparam logic [3:0] AN_S1 = 4'b1101;
  localparam logic [3:0] AN_M0 = 4'b1011;
  localparam logic [3:0] AN_M1 = 4'b0111;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is held off, codes above 9 blank the digit.
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] anode_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return AN_S0;
      2'd1:    return AN_S1;
      2'd2:    return AN_M0;
      default: return AN_M1;
    endcase
  endfunction

  // Two-digit BCD value {tens,ones}; max_v wraps to 00 on increment.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    if (v == max_v)         return 8'h00;
    if (v[3:0] == 4'd9)     return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // 00 wraps to max_v on decrement.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
    if (v == 8'h00)         return max_v;
    if (v[3:0] == 4'd0)     return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-cycle tick enable every DIV clocks; hold parks the count at zero so the
// first tick after release arrives exactly DIV cycles later.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = !hold && (cnt == W'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (hold || tick) cnt <= '0;
    else                  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/mmss_timer.sv
// MM:SS up/down timer with field adjust, blinking selected field, sticky
// countdown-done flag and a 4-digit multiplexed seven-segment driver.
module mmss_timer
  import mmss_timer_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int RUN_HZ   = 1,
  parameter int ADJ_HZ   = 2,
  parameter int SCAN_HZ  = 500,
  parameter int BLINK_HZ = 2,
  parameter int MIN_MAX  = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause_pulse,
  input  logic       sel,
  input  logic       adj,
  input  logic       down,
  input  logic       done_clr,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       done
);

  localparam int DIV_RUN   = CLK_FREQ / RUN_HZ;
  localparam int DIV_ADJ   = CLK_FREQ / ADJ_HZ;
  localparam int DIV_SCAN  = CLK_FREQ / SCAN_HZ;
  localparam int DIV_BLINK = CLK_FREQ / (2 * BLINK_HZ);

  localparam logic [7:0] MIN_MAX_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

  logic [7:0] min_q, sec_q, min_nx, sec_nx;
  logic       running, blink, set_done;
  logic [1:0] scan_idx;
  logic       run_tick, adj_tick, scan_tick, blink_tick;

  logic [3:0] digit;
  field_e     idx_field;
  logic       blank;

  // Run divider restarts from zero whenever counting is suspended.
  tick_gen #(.DIV(DIV_RUN)) u_run (
    .clk(clk), .rst(rst), .hold(!running || adj), .tick(run_tick)
  );
  tick_gen #(.DIV(DIV_ADJ)) u_adj (
    .clk(clk), .rst(rst), .hold(1'b0), .tick(adj_tick)
  );
  tick_gen #(.DIV(DIV_SCAN)) u_scan (
    .clk(clk), .rst(rst), .hold(1'b0), .tick(scan_tick)
  );
  tick_gen #(.DIV(DIV_BLINK)) u_blink (
    .clk(clk), .rst(rst), .hold(1'b0), .tick(blink_tick)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    min_nx   = min_q;
    sec_nx   = sec_q;
    set_done = 1'b0;
    if (adj) begin
      if (adj_tick) begin
        if (field_e'(sel) == FIELD_SEC)
          sec_nx = down ? bcd_dec(sec_q, SEC_MAX_BCD) : bcd_inc(sec_q, SEC_MAX_BCD);
        else
          min_nx = down ? bcd_dec(min_q, MIN_MAX_BCD) : bcd_inc(min_q, MIN_MAX_BCD);
      end
    end else if (run_tick) begin
      if (!down) begin
        sec_nx = bcd_inc(sec_q, SEC_MAX_BCD);
        if (sec_q == SEC_MAX_BCD) min_nx = bcd_inc(min_q, MIN_MAX_BCD);
      end else if (min_q == 8'h00 && sec_q == 8'h00) begin
        set_done = 1'b1;
      end else begin
        sec_nx = bcd_dec(sec_q, SEC_MAX_BCD);
        if (sec_q == 8'h00) min_nx = bcd_dec(min_q, MIN_MAX_BCD);
        if (min_q == 8'h00 && sec_q == 8'h01) set_done = 1'b1;
      end
    end
  end

  always_comb begin
    digit = sec_q[3:0];
    case (scan_idx)
      2'd0:    digit = sec_q[3:0];
      2'd1:    digit = sec_q[7:4];
      2'd2:    digit = min_q[3:0];
      default: digit = min_q[7:4];
    endcase
    idx_field = scan_idx[1] ? FIELD_MIN : FIELD_SEC;
    blank     = adj && blink && (idx_field == field_e'(sel));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q    <= 8'h00;
      sec_q    <= 8'h00;
      running  <= 1'b1;
      done     <= 1'b0;
      blink    <= 1'b0;
      scan_idx <= 2'd0;
      an       <= 4'b1111;
      seg      <= SEG_BLANK;
    end else begin
      min_q <= min_nx;
      sec_q <= sec_nx;
      if (pause_pulse) running <= !running;
      // A set in the same cycle as a clear wins.
      done <= set_done || (done && !done_clr);
      if (blink_tick) blink <= !blink;
      if (scan_tick)  scan_idx <= scan_idx + 2'd1;
      an  <= anode_of(scan_idx);
      seg <= blank ? SEG_BLANK : bcd_to_seg(digit);
    end
  end

endmodule

// File: tb/tb_mmss_timer.sv
// Self-checking bench for mmss_timer: directed steps followed by random
// stimulus, compared every cycle against a total-seconds reference model.
module tb_mmss_timer;

  localparam int CLK_FREQ = 1000;
  localparam int RUN_HZ   = 100;
  localparam int ADJ_HZ   = 200;
  localparam int SCAN_HZ  = 500;
  localparam int BLINK_HZ = 50;
  localparam int MIN_MAX  = 59;

  localparam int D_RUN  = CLK_FREQ / RUN_HZ;
  localparam int D_ADJ  = CLK_FREQ / ADJ_HZ;
  localparam int D_SCAN = CLK_FREQ / SCAN_HZ;
  localparam int D_HALF = CLK_FREQ / (2 * BLINK_HZ);
  localparam int N_TOT  = (MIN_MAX + 1) * 60;

  localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause_pulse = 1'b0;
  logic       sel = 1'b0;
  logic       adj = 1'b0;
  logic       down = 1'b0;
  logic       done_clr = 1'b0;
  logic [7:0] seg;
  logic [3:0] an;
  logic       done;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int         m_tot, m_idx, m_k, m_run_age;
  bit         m_running, m_done, m_blink;
  logic [3:0] m_an;
  logic [7:0] m_seg;

  mmss_timer #(
    .CLK_FREQ(CLK_FREQ), .RUN_HZ(RUN_HZ), .ADJ_HZ(ADJ_HZ),
    .SCAN_HZ(SCAN_HZ), .BLINK_HZ(BLINK_HZ), .MIN_MAX(MIN_MAX)
  ) dut (
    .clk(clk), .rst(rst), .pause_pulse(pause_pulse), .sel(sel), .adj(adj),
    .down(down), .done_clr(done_clr), .seg(seg), .an(an), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tot = 0; m_idx = 0; m_k = 0; m_run_age = 0;
    m_running = 1'b1; m_done = 1'b0; m_blink = 1'b0;
    m_an = 4'b1111; m_seg = 8'hFF;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int mm, ss, dig;
    bit rt, at, set_d;
    mm = m_tot / 60;
    ss = m_tot % 60;
    case (m_idx)
      0:       dig = ss % 10;
      1:       dig = ss / 10;
      2:       dig = mm % 10;
      default: dig = mm / 10;
    endcase
    m_an  = ~(4'b0001 << m_idx);
    m_seg = (adj && m_blink && ((m_idx < 2) == sel)) ? 8'hFF : SEG_TAB[dig];

    rt = 1'b0;
    if (m_running && !adj) begin
      rt = (m_run_age % D_RUN) == D_RUN - 1;
      m_run_age++;
    end else begin
      m_run_age = 0;
    end
    at = (m_k % D_ADJ) == D_ADJ - 1;

    set_d = 1'b0;
    if (adj) begin
      if (at) begin
        if (sel) ss = (ss + (down ? 59 : 1)) % 60;
        else     mm = (mm + (down ? MIN_MAX : 1)) % (MIN_MAX + 1);
        m_tot = mm * 60 + ss;
      end
    end else if (rt) begin
      if (!down)           m_tot = (m_tot + 1) % N_TOT;
      else if (m_tot == 0) set_d = 1'b1;
      else begin
        m_tot--;
        if (m_tot == 0) set_d = 1'b1;
      end
    end
    m_done = set_d ? 1'b1 : (done_clr ? 1'b0 : m_done);
    if (pause_pulse) m_running = !m_running;
    if ((m_k % D_HALF) == D_HALF - 1) m_blink = !m_blink;
    if ((m_k % D_SCAN) == D_SCAN - 1) m_idx = (m_idx + 1) % 4;
    m_k++;
  endtask

  task automatic check_all();
    chk("an", 32'(an), 32'(m_an));
    chk("seg", 32'(seg), 32'(m_seg));
    chk("done", 32'(done), 32'(m_done));
    chk("running", 32'(dut.running), 32'(m_running));
    chk("mmss", 32'({dut.min_q, dut.sec_q}), 32'({bcd8(m_tot / 60), bcd8(m_tot % 60)}));
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic pulse_pause();
    pause_pulse = 1'b1;
    step();
    pause_pulse = 1'b0;
  endtask

  task automatic chk_time(input string tag, input int mm, input int ss);
    chk(tag, 32'({dut.min_q, dut.sec_q}), 32'({bcd8(mm), bcd8(ss)}));
  endtask

  int snap, n_blank;

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", 32'(an), 32'h0000_000F);
    chk("rst_seg", 32'(seg), 32'h0000_00FF);
    chk("rst_done", 32'(done), 32'h0);
    chk_time("rst_time", 0, 0);
    rst = 1'b0;

    // Up-count carry into minutes, then full wrap from MIN_MAX:59.
    step(600);
    chk_time("up_carry", 1, 0);
    adj = 1'b1; sel = 1'b0; down = 1'b1;
    step(10);
    chk_time("preload_min", 59, 0);
    sel = 1'b1;
    step(5);
    chk_time("preload_sec", 59, 59);
    adj = 1'b0; down = 1'b0;
    step(10);
    chk_time("up_wrap", 0, 0);
    chk("up_wrap_done", 32'(done), 32'h0);

    // Countdown to expiry, hold at zero, clear.
    adj = 1'b1; sel = 1'b1;
    step(10);
    chk_time("set_0002", 0, 2);
    adj = 1'b0; down = 1'b1;
    step(10);
    chk_time("down_0001", 0, 1);
    chk("down_0001_done", 32'(done), 32'h0);
    step(10);
    chk_time("down_0000", 0, 0);
    chk("expired", 32'(done), 32'h1);
    step(20);
    chk_time("hold_0000", 0, 0);
    chk("still_done", 32'(done), 32'h1);
    done_clr = 1'b1;
    step();
    done_clr = 1'b0;
    chk("done_cleared", 32'(done), 32'h0);

    // Pause freezes the count; resume gives the next step exactly D_RUN later.
    down = 1'b0;
    step(50);
    chk_time("count_05", 0, 5);
    pulse_pause();
    snap = m_tot;
    step(500);
    chk("paused_hold", 32'({dut.min_q, dut.sec_q}), 32'({bcd8(snap / 60), bcd8(snap % 60)}));
    pulse_pause();
    step(D_RUN - 1);
    chk("resume_early", 32'({dut.min_q, dut.sec_q}), 32'({bcd8(snap / 60), bcd8(snap % 60)}));
    step();
    chk("resume_tick", 32'({dut.min_q, dut.sec_q}),
        32'({bcd8((snap + 1) / 60), bcd8((snap + 1) % 60)}));

    // Adjust wraps each field without touching the other.
    adj = 1'b1; sel = 1'b0; down = 1'b1;
    step(5);
    chk_time("adj_min_wrap", 59, 6);
    sel = 1'b1;
    step(35);
    chk_time("adj_sec_to59", 59, 59);
    down = 1'b0;
    step(5);
    chk_time("adj_sec_wrap", 59, 0);

    // Display scan at 12:34.
    sel = 1'b0; down = 1'b1;
    step(235);
    sel = 1'b1; down = 1'b0;
    step(170);
    chk_time("set_1234", 12, 34);
    pulse_pause();
    adj = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      case (an)
        4'b1110: chk("scan_s0", 32'(seg), 32'h99);
        4'b1101: chk("scan_s1", 32'(seg), 32'hB0);
        4'b1011: chk("scan_m0", 32'(seg), 32'hA4);
        4'b0111: chk("scan_m1", 32'(seg), 32'hF9);
        default: chk("scan_an", 32'(an), 32'h0000_000E);
      endcase
    end
    adj = 1'b1; sel = 1'b1;
    n_blank = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (an[1:0] != 2'b11) begin
        if (seg == 8'hFF) n_blank++;
      end else begin
        chk("min_no_blank", 32'(seg == 8'hFF), 32'h0);
      end
    end
    chk("sec_blinked", 32'(n_blank > 0), 32'h1);
    adj = 1'b0;
    pulse_pause();

    // Random mode changes, pauses and clears.
    for (int i = 0; i < 2000; i++) begin
      pause_pulse = ($urandom_range(0, 99) == 0);
      done_clr    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 149) == 0) begin
        adj  = ($urandom_range(0, 3) == 0);
        down = $urandom_range(0, 1) != 0;
        sel  = $urandom_range(0, 1) != 0;
      end
      step();
    end
    pause_pulse = 1'b0;
    done_clr = 1'b0;

    // Asynchronous reset between clock edges.
    adj = 1'b1; sel = 1'b0; down = 1'b0;
    step(12);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", 32'(an), 32'h0000_000F);
    chk("arst_seg", 32'(seg), 32'h0000_00FF);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_running", 32'(dut.running), 32'h1);
    chk_time("arst_time", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
